// File: rtl/pingpang_wr_ctrl.sv
// pingpang_wr_ctrl: streams samples into alternating ping-pong RAM banks.
// A bank is marked full once its last write lands and stays full until the reader releases it.
module pingpang_wr_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    output logic              full_a,
    output logic              full_b,
    input  logic              rel_a,
    input  logic              rel_b,
    output logic              wr_bank,
    output logic [15:0]       stall_cnt
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d, addra_q, addra_d, addrb_q, addrb_d;
    logic [DATA_W-1:0] dina_q, dina_d, dinb_q, dinb_d;
    logic              wea_q, wea_d, web_q, web_d, wr_bank_q, wr_bank_d;
    logic              full_a_q, full_a_d, full_b_q, full_b_d;
    logic              set_a_q, set_a_d, set_b_q, set_b_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              acc, wrap;

    assign din_ready = ~(wr_bank_q ? full_b_q : full_a_q);

    always_comb begin
        acc         = din_valid & din_ready;
        wrap        = acc & (cnt_q == LAST);
        cnt_d       = acc ? (wrap ? '0 : cnt_q + ADDR_W'(1)) : cnt_q;
        wr_bank_d   = wr_bank_q ^ wrap;
        wea_d       = acc & ~wr_bank_q;
        web_d       = acc & wr_bank_q;
        addra_d     = wea_d ? cnt_q : addra_q;
        dina_d      = wea_d ? din : dina_q;
        addrb_d     = web_d ? cnt_q : addrb_q;
        dinb_d      = web_d ? din : dinb_q;
        // full is delayed one extra cycle so it only rises after the last RAM write is done
        set_a_d     = wrap & ~wr_bank_q;
        set_b_d     = wrap & wr_bank_q;
        full_a_d    = set_a_q | (full_a_q & ~rel_a);
        full_b_d    = set_b_q | (full_b_q & ~rel_b);
        stall_cnt_d = (din_valid & ~din_ready & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            wr_bank_q   <= 1'b0;
            wea_q       <= 1'b0;
            web_q       <= 1'b0;
            addra_q     <= '0;
            addrb_q     <= '0;
            dina_q      <= '0;
            dinb_q      <= '0;
            set_a_q     <= 1'b0;
            set_b_q     <= 1'b0;
            full_a_q    <= 1'b0;
            full_b_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wr_bank_q   <= wr_bank_d;
            wea_q       <= wea_d;
            web_q       <= web_d;
            addra_q     <= addra_d;
            addrb_q     <= addrb_d;
            dina_q      <= dina_d;
            dinb_q      <= dinb_d;
            set_a_q     <= set_a_d;
            set_b_q     <= set_b_d;
            full_a_q    <= full_a_d;
            full_b_q    <= full_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wea       = wea_q;
    assign web       = web_q;
    assign addra     = addra_q;
    assign addrb     = addrb_q;
    assign dina      = dina_q;
    assign dinb      = dinb_q;
    assign full_a    = full_a_q;
    assign full_b    = full_b_q;
    assign wr_bank   = wr_bank_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: doc/pingpang_wr_ctrl.md
Name: pingpang_wr_ctrl

Overview:
- Upstream write stage of the ping-pong RAM pair (bank A on port a, bank B on port b; each 1024 x 14).
- Accepts a valid/ready sample stream and writes DEPTH consecutive samples into bank A, then bank B, alternating.
- Marks a bank full when its last sample is committed, and stalls the stream while the next bank is still held by the downstream reader.
- The reader frees a bank with a one-cycle release pulse.

Parameters:
- DATA_W, 14, sample and RAM data width
- ADDR_W, 10, RAM address width
- DEPTH, 1024, samples per bank; must satisfy 2 <= DEPTH <= 2^ADDR_W

Ports:
- clk  in  1  single clock for the block and both RAM write ports
- rst  in  1  synchronous reset, active-high
- din_valid  in  1  upstream sample valid
- din  in  DATA_W  upstream sample
- din_ready  out  1  block can accept a sample this cycle (combinational from registered state)
- wea  out  1  bank A write enable
- addra  out  ADDR_W  bank A write address
- dina  out  DATA_W  bank A write data
- web  out  1  bank B write enable
- addrb  out  ADDR_W  bank B write address
- dinb  out  DATA_W  bank B write data
- full_a  out  1  bank A holds DEPTH valid samples and is owned by the reader
- full_b  out  1  same, for bank B
- rel_a  in  1  reader release pulse for bank A
- rel_b  in  1  reader release pulse for bank B
- wr_bank  out  1  bank currently being filled (0 = A, 1 = B)
- stall_cnt  out  16  cycles with din_valid=1 and din_ready=0; saturates at 0xFFFF

Behaviour:
- Reset values:
  - wea=0, web=0
  - addra=0, addrb=0, dina=0, dinb=0
  - full_a=0, full_b=0
  - wr_bank=0, stall_cnt=0
  - Internal write counter = 0.
- din_ready = NOT full[wr_bank]. It is independent of din_valid.
- Accept: din_valid & din_ready in cycle N.
- Write latency: a sample accepted in cycle N drives the selected bank's we/addr/din registers during cycle N+1.
  - we is high for exactly one cycle per accepted sample.
  - The other bank's we is 0.
  - addr and din hold their last values when we=0.
- Address: the k-th sample of a fill (k = 0..DEPTH-1) is written to address k.
- Fill completion: on acceptance of sample k = DEPTH-1 in cycle N:
  - Counter wraps to 0 and wr_bank toggles at the end of cycle N.
  - The full flag of the completed bank rises at the start of N+2, i.e. after the RAM write in N+1 has completed.
  - This applies for every DEPTH, including DEPTH < 2^ADDR_W.
- Stall: if the new wr_bank is still full, din_ready=0 and the fill counter holds. stall_cnt increments each cycle with din_valid=1 and din_ready=0.
- Release: rel_x=1 while full_x=1 clears full_x at the next edge.
  - rel_x while full_x=0 is ignored. This covers a release in the N+1 gap before the flag rises.
  - rel_a and rel_b in the same cycle are handled independently.
- Back-to-back: a release in cycle M on the stalled bank lets din_ready rise in M+1. Zero bubbles are allowed when both banks are free.
- Simultaneous events: the fill-completion set and a release of the same bank cannot collide, because the set only occurs from full=0.
- Reset mid-operation:
  - Every register returns to its reset value at the next edge.
  - A write scheduled for the following cycle is dropped (we=0).
  - Partially filled banks are discarded.
  - full flags are cleared without any release.
- No combinational path from din_valid/din to any RAM port; all RAM port outputs are registers.

Test Plan:
- After reset, stream 1024 samples 0..1023 with valid held high:
  - wea pulses 1024 consecutive cycles, addra=0..1023, dina equal to the sample value.
  - full_a rises 2 cycles after sample 1023 is accepted.
  - wr_bank=1 and web starts 1 cycle later with addrb=0.
- Fill A and B with no releases:
  - din_ready=0 after the 2048th accept.
  - Hold din_valid=1 for 20 cycles: stall_cnt=20, no we pulses.
  - Pulse rel_a: din_ready=1 next cycle, next sample written to addra=0.
- Random din_valid gaps (50%) over 3 bank fills with prompt releases:
  - Every accepted sample appears exactly once, in order, at the correct bank/address.
  - No we on idle cycles.
- rel_b pulsed while bank B is being filled (full_b=0): ignored, so full_b still rises at fill end. rel_a and rel_b asserted together while both full: both clear on the same edge.
- Assert rst after 500 samples of bank B with full_a=1:
  - Next cycle: wea=web=0, full_a=0, wr_bank=0.
  - The next accepted sample is written to addra=0.
- DEPTH=16 build: full_a after 16 samples, addresses 0..15 only, wrap to bank B, stall_cnt saturates at 0xFFFF under a long forced stall.
